display_scan_ctrl: RTL and testbench

Scan scheduler for the four-digit seven-segment display. It time-multiplexes a 16-bit word of four 4-bit digit codes onto the anodes and selects one digit code per slot for the downstream BCD decoder. New words are accepted through a load handshake and applied only at frame boundaries, so a frame never shows two different words. It replaces the free-running clock-divider mux select in the multiplexed display path.

---
 rtl/display_scan_ctrl_if.sv | 13 +
 rtl/display_scan_ctrl.sv | 113 +++++++++++
 tb/tb_display_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Load channel of the display scan controller: the producer offers a 16-bit
// word of four digit codes and the controller acknowledges each capture.
interface display_scan_ctrl_if;
  // Handshake: data is valid in every cycle where ld=1 and is captured on that
  // rising edge. ld_ack is high in the cycle after each capture. Capture is
  // unconditional, so holding ld high recaptures every cycle and ld_ack stays high.
  logic        ld;
  logic [15:0] data;
  logic        ld_ack;

  modport master (output ld, output data, input ld_ack);
  modport slave  (input ld, input data, output ld_ack);
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with frame-synchronous word updates.
// Optional per-slot anode blanking is enabled by defining SCAN_BLANKING_EN.
module display_scan_ctrl #(
  parameter int PRESCALE     = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  display_scan_ctrl_if.slave         ld_bus,
  input  logic [3:0]                 dig_en,
  output logic [3:0]                 code,
  output logic [1:0]                 dig_sel,
  output logic [3:0]                 an,
  output logic                       frame_done,
  output logic                       state_dbg
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [15:0] SLOT_LAST  = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  // Without blanking every slot opens directly in SHOW and BLANK is unreachable.
`ifdef SCAN_BLANKING_EN
  localparam scan_state_e SLOT_ENTRY = BLANK;
`else
  localparam scan_state_e SLOT_ENTRY = SHOW;
`endif

  scan_state_e state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [1:0]  d, d_nx;
  logic [15:0] shadow, shadow_nx;
  logic [15:0] active, active_nx;
  logic        wrap;
  logic [3:0]  an_nx;
  logic [3:0]  code_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_ENTRY;
      cnt   <= '0;
      d     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      d     <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 16'd1;
    d_nx     = d;
    wrap     = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_nx = SHOW;
      end
      SHOW: begin
        if (cnt == SLOT_LAST) begin
          cnt_nx   = '0;
          d_nx     = d + 2'd1;
          state_nx = SLOT_ENTRY;
          wrap     = (d == 2'd3);
        end
      end
      default: state_nx = SLOT_ENTRY;
    endcase
  end

  // A load on the wrap edge goes straight to the active word so the new frame
  // already shows it; otherwise the frame adopts whatever shadow holds.
  always_comb begin
    shadow_nx = ld_bus.ld ? ld_bus.data : shadow;
    active_nx = active;
    if (wrap) active_nx = ld_bus.ld ? ld_bus.data : shadow;
  end

  // Outputs are registered from the post-edge state so they line up with
  // the cycle they describe, with no input-to-output combinational path.
  always_comb begin
    an_nx = 4'b1111;
    if (state_nx == SHOW && dig_en[d_nx]) an_nx = ~(4'b0001 << d_nx);
    code_nx = active_nx[{d_nx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= '0;
      active        <= '0;
      an            <= 4'b1111;
      code          <= '0;
      dig_sel       <= '0;
      ld_bus.ld_ack <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      shadow        <= shadow_nx;
      active        <= active_nx;
      an            <= an_nx;
      code          <= code_nx;
      dig_sel       <= d_nx;
      ld_bus.ld_ack <= ld_bus.ld;
      frame_done    <= wrap;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4, BLANK_CYCLES=1; the
// expected anode tables follow whether SCAN_BLANKING_EN is defined.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig_en;
  logic [3:0] code;
  logic [1:0] dig_sel;
  logic [3:0] an;
  logic       frame_done;
  logic       state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_bus     (bus),
    .dig_en     (dig_en),
    .code       (code),
    .dig_sel    (dig_sel),
    .an         (an),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Per-cycle anode values over one 16-cycle frame, cycle 0 = first cycle of digit 0.
`ifdef SCAN_BLANKING_EN
  logic [3:0] an_all  [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [3:0] an_0101 [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
  logic       entry_state = 1'b0;
`else
  logic [3:0] an_all  [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                               4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7};
  logic [3:0] an_0101 [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                               4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
  logic       entry_state = 1'b1;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  // First frame after reset release: the anode register still holds its reset
  // value in cycle 0, which the blanking table already has as all-off.
  task automatic first_frame(input logic [3:0] exp_code1);
    for (int c = 0; c < 16; c++) begin
      goto(c);
      check("first_an", 16'(an), 16'((c == 0) ? 4'hF : an_all[c]));
      check("first_dig_sel", 16'(dig_sel), 16'(c / 4));
      check("first_frame_done", 16'(frame_done), 16'd0);
      if (c == 4) check("first_code1", 16'(code), 16'(exp_code1));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    dig_en  = 4'hF;
    bus.ld   = 1'b0;
    bus.data = 16'h0000;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_an", 16'(an), 16'hF);
    check("rst_code", 16'(code), 16'h0);
    check("rst_dig_sel", 16'(dig_sel), 16'h0);
    check("rst_ld_ack", 16'(bus.ld_ack), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_state", 16'(state_dbg), 16'(entry_state));

    rst_n = 1'b1;
    cyc   = 0;
    first_frame(4'h0);
    goto(16);
    check("f1_frame_done", 16'(frame_done), 16'd1);
    check("f1_an", 16'(an), 16'(an_all[0]));
    goto(17);
    check("f1_frame_done_low", 16'(frame_done), 16'd0);

    // Mid-frame load during the digit-1 slot
    goto(21);
    bus.ld = 1'b1; bus.data = 16'h4321;
    goto(22);
    bus.ld = 1'b0;
    check("ld_ack_pulse", 16'(bus.ld_ack), 16'd1);
    check("code_held", 16'(code), 16'h0);
    goto(23);
    check("ld_ack_low", 16'(bus.ld_ack), 16'd0);
    goto(31);
    check("code_before_wrap", 16'(code), 16'h0);
    goto(32);
    check("wrap_frame_done", 16'(frame_done), 16'd1);
    check("wrap_code0", 16'(code), 16'h1);
    goto(33);
    check("wrap_frame_done_low", 16'(frame_done), 16'd0);
    goto(36); check("code_d1", 16'(code), 16'h2);
    goto(40); check("code_d2", 16'(code), 16'h3);
    goto(44); check("code_d3", 16'(code), 16'h4);
    check("dig_sel_d3", 16'(dig_sel), 16'd3);

    // Load on the exact wrap edge bypasses shadow
    goto(47);
    bus.ld = 1'b1; bus.data = 16'hABCD;
    goto(48);
    bus.ld = 1'b0;
    check("bypass_code0", 16'(code), 16'hD);
    check("bypass_frame_done", 16'(frame_done), 16'd1);
    check("bypass_ld_ack", 16'(bus.ld_ack), 16'd1);
    goto(52);
    check("bypass_code1", 16'(code), 16'hC);

    // Digits 1 and 3 disabled for one frame
    goto(63);
    dig_en = 4'b0101;
    for (int c = 64; c < 80; c++) begin
      goto(c);
      check("en0101_an", 16'(an), 16'(an_0101[c - 64]));
    end
    goto(80);
    check("en0101_frame_done", 16'(frame_done), 16'd1);
    dig_en = 4'hF;

    // Asynchronous reset in the digit-2 SHOW phase
    goto(90);
    check("pre_rst_an", 16'(an), 16'hB);
    check("pre_rst_code", 16'(code), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 16'(an), 16'hF);
    check("async_rst_code", 16'(code), 16'h0);
    check("async_rst_dig_sel", 16'(dig_sel), 16'h0);
    check("async_rst_state", 16'(state_dbg), 16'(entry_state));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    first_frame(4'h0);
    goto(16);
    check("post_rst_frame_done", 16'(frame_done), 16'd1);
    check("post_rst_code0", 16'(code), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
